// File: rtl/sd_dat_pkg.sv
// Shared state encoding and default parameter values for the SD DAT PHY sequencer.
package sd_dat_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int BLKCNT_W_DEF = 16;
    localparam int TO_W_DEF     = 32;
    localparam int RESP_DLY_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_RESP,
        ST_READ,
        ST_PUSH,
        ST_WRAP_RST,
        ST_WAIT_ACK
    } sd_dat_state_t;

endpackage

// File: rtl/sd_timeout_cnt.sv
// Saturating cycle counter: holds 0 while clear, counts up while enabled (first enabled cycle reads 1).
// expired flags count == limit for a nonzero limit; a zero limit never expires.
module sd_timeout_cnt #(
    parameter int TO_W = 32
) (
    input  logic            sd_clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    input  logic [TO_W-1:0] limit,
    output logic [TO_W-1:0] count,
    output logic            expired
);

    always_ff @(posedge sd_clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + TO_W'(1);
        end
    end

    assign expired = (limit != '0) && (count == limit);

endmodule

// File: rtl/sd_dat_phy_fsm.sv
// SD DAT PHY sequencer: write = load/send/response per block, read = receive/push/wrapper-reset per block.
// Moore control decode; FIFO strobes are further qualified by the FIFO flags, reset and abort.
module sd_dat_phy_fsm
    import sd_dat_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BLKCNT_W = BLKCNT_W_DEF,
    parameter int TO_W     = TO_W_DEF,
    parameter int RESP_DLY = RESP_DLY_DEF
) (
    input  logic                sd_clock,
    input  logic                reset,
    input  logic                strobe_in,
    input  logic                ack_in,
    input  logic                idle_in,
    input  logic                write_read,
    input  logic                multiple,
    input  logic [BLKCNT_W-1:0] blocks,
    input  logic [TO_W-1:0]     timeout_val,
    output logic                serial_ready,
    output logic                complete,
    output logic                ack_out,
    output logic                error_timeout,
    output logic [BLKCNT_W-1:0] blocks_done,
    input  logic                transmission_complete,
    input  logic                reception_complete,
    input  logic [DATA_W-1:0]   data_read,
    output logic                reset_wrapper,
    output logic                load_send,
    output logic                enable_pts,
    output logic                enable_stp,
    output logic                waiting_response,
    output logic                pad_state,
    output logic                pad_enable,
    input  logic                fifo_empty,
    input  logic                fifo_full,
    output logic                fifo_rd_en,
    output logic                fifo_wr_en,
    output logic [DATA_W-1:0]   fifo_wdata
);

    sd_dat_state_t       state, state_nxt;
    logic [BLKCNT_W-1:0] target_q;
    logic [TO_W-1:0]     timeout_q;
    logic [TO_W-1:0]     to_count;
    logic                to_expired;
    logic                rx_state, rx_next, last_rx, last_push, strobe_ok;

    assign rx_state  = (state == ST_WAIT_RESP) || (state == ST_READ);
    assign rx_next   = (state_nxt == ST_WAIT_RESP) || (state_nxt == ST_READ);
    assign last_rx   = (blocks_done + BLKCNT_W'(1)) == target_q;
    assign last_push = (blocks_done == target_q);
    assign strobe_ok = !reset && !idle_in;

    // Counter is zero outside the receive states, so expiry can only fire there.
    sd_timeout_cnt #(.TO_W(TO_W)) u_timeout (
        .sd_clock (sd_clock),
        .reset    (reset),
        .clear    (!rx_next),
        .enable   (rx_next),
        .limit    (timeout_q),
        .count    (to_count),
        .expired  (to_expired)
    );

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            blocks_done   <= '0;
            error_timeout <= 1'b0;
            fifo_wdata    <= '0;
            target_q      <= BLKCNT_W'(1);
            timeout_q     <= '0;
        end else begin
            state <= state_nxt;
            if (!idle_in) begin
                if (state == ST_IDLE && strobe_in) begin
                    blocks_done   <= '0;
                    error_timeout <= 1'b0;
                    target_q      <= (!multiple || blocks == '0) ? BLKCNT_W'(1) : blocks;
                    timeout_q     <= timeout_val;
                end
                if (rx_state && reception_complete) begin
                    blocks_done <= blocks_done + BLKCNT_W'(1);
                end
                if (state == ST_READ && reception_complete) begin
                    fifo_wdata <= data_read;
                end
                if (rx_state && to_expired && !reception_complete) begin
                    error_timeout <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (strobe_in) state_nxt = write_read ? ST_LOAD : ST_READ;
            ST_LOAD:      if (!fifo_empty) state_nxt = ST_SEND;
            ST_SEND:      if (transmission_complete) state_nxt = ST_WAIT_RESP;
            ST_WAIT_RESP: begin
                if (reception_complete) state_nxt = last_rx ? ST_WAIT_ACK : ST_LOAD;
                else if (to_expired)    state_nxt = ST_WAIT_ACK;
            end
            ST_READ: begin
                if (reception_complete) state_nxt = ST_PUSH;
                else if (to_expired)    state_nxt = ST_WAIT_ACK;
            end
            ST_PUSH:      if (!fifo_full) state_nxt = last_push ? ST_WAIT_ACK : ST_WRAP_RST;
            ST_WRAP_RST:  state_nxt = ST_READ;
            ST_WAIT_ACK:  if (ack_in) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        if (idle_in) state_nxt = ST_IDLE;
    end

    always_comb begin
        serial_ready     = 1'b0;
        reset_wrapper    = 1'b0;
        complete         = 1'b0;
        ack_out          = 1'b0;
        load_send        = 1'b0;
        enable_pts       = 1'b0;
        enable_stp       = 1'b0;
        waiting_response = 1'b0;
        pad_state        = 1'b0;
        pad_enable       = 1'b0;
        fifo_rd_en       = 1'b0;
        fifo_wr_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                serial_ready  = 1'b1;
                reset_wrapper = 1'b1;
            end
            ST_LOAD: begin
                enable_pts = 1'b1;
                pad_state  = 1'b1;
                pad_enable = 1'b1;
                fifo_rd_en = !fifo_empty && strobe_ok;
            end
            ST_SEND: begin
                load_send  = 1'b1;
                enable_pts = 1'b1;
                pad_state  = 1'b1;
                pad_enable = 1'b1;
            end
            ST_WAIT_RESP: begin
                waiting_response = 1'b1;
                pad_enable       = 1'b1;
                // to_count reads k+1 in the k-th cycle of the state
                enable_stp       = to_count > TO_W'(RESP_DLY);
            end
            ST_READ: begin
                enable_stp = 1'b1;
                pad_enable = 1'b1;
            end
            ST_PUSH:     fifo_wr_en = !fifo_full && strobe_ok;
            ST_WRAP_RST: reset_wrapper = 1'b1;
            ST_WAIT_ACK: begin
                complete = 1'b1;
                ack_out  = ack_in;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sd_dat_phy_fsm.sv
// Randomised bench for sd_dat_phy_fsm: a reactive wrapper/FIFO driver plus a block-level outcome model.
module tb_sd_dat_phy_fsm;

    logic        sd_clock, reset;
    logic        strobe_in, ack_in, idle_in, write_read, multiple;
    logic [15:0] blocks;
    logic [31:0] timeout_val;
    logic        serial_ready, complete, ack_out, error_timeout;
    logic [15:0] blocks_done;
    logic        transmission_complete, reception_complete;
    logic [31:0] data_read;
    logic        reset_wrapper, load_send, enable_pts, enable_stp, waiting_response;
    logic        pad_state, pad_enable;
    logic        fifo_empty, fifo_full, fifo_rd_en, fifo_wr_en;
    logic [31:0] fifo_wdata;

    int n_pass = 0;
    int n_total = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int wrap_cnt = 0;
    int recv_cycles = 0;
    logic [31:0] wq[$];
    int          rx_idx[8];
    logic [31:0] rx_dat[8];

    sd_dat_phy_fsm dut (
        .sd_clock(sd_clock), .reset(reset), .strobe_in(strobe_in), .ack_in(ack_in),
        .idle_in(idle_in), .write_read(write_read), .multiple(multiple), .blocks(blocks),
        .timeout_val(timeout_val), .serial_ready(serial_ready), .complete(complete),
        .ack_out(ack_out), .error_timeout(error_timeout), .blocks_done(blocks_done),
        .transmission_complete(transmission_complete), .reception_complete(reception_complete),
        .data_read(data_read), .reset_wrapper(reset_wrapper), .load_send(load_send),
        .enable_pts(enable_pts), .enable_stp(enable_stp), .waiting_response(waiting_response),
        .pad_state(pad_state), .pad_enable(pad_enable), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_rd_en(fifo_rd_en), .fifo_wr_en(fifo_wr_en),
        .fifo_wdata(fifo_wdata)
    );

    initial sd_clock = 1'b0;
    always #5 sd_clock = ~sd_clock;

    always @(negedge sd_clock) begin
        if (fifo_rd_en === 1'b1) rd_cnt++;
        if (fifo_wr_en === 1'b1) begin
            wr_cnt++;
            wq.push_back(fifo_wdata);
        end
        if (reset_wrapper === 1'b1 && serial_ready === 1'b0) wrap_cnt++;
    end

    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    task automatic clear_inputs();
        strobe_in = 0; ack_in = 0; idle_in = 0;
        transmission_complete = 0; reception_complete = 0;
        fifo_empty = 1; fifo_full = 0;
    endtask

    // Plays wrapper and FIFO: random handshakes, reception on the cycle index chosen per block.
    task automatic drive_xfer(input bit wr, input bit mult, input logic [15:0] nblk,
                              input logic [31:0] to_val, output bit hung);
        int blk = 0;
        int k = 0;
        int guard = 0;
        write_read = wr; multiple = mult; blocks = nblk; timeout_val = to_val;
        strobe_in = 1;
        tick();
        strobe_in = 0;
        recv_cycles = 0;
        while (complete !== 1'b1 && guard < 2000) begin
            transmission_complete = 0;
            reception_complete = 0;
            fifo_empty = ($urandom_range(0, 2) == 0);
            fifo_full  = ($urandom_range(0, 2) == 0);
            if (load_send === 1'b1) transmission_complete = ($urandom_range(0, 2) == 0);
            if (pad_enable === 1'b1 && pad_state === 1'b0 && blk < 8) begin
                recv_cycles++;
                if (k == rx_idx[blk]) begin
                    reception_complete = 1;
                    data_read = rx_dat[blk];
                    blk++;
                    k = 0;
                end else begin
                    k++;
                end
            end
            tick();
            guard++;
        end
        clear_inputs();
        #1;
        hung = (complete !== 1'b1);
    endtask

    task automatic test_transfer(input string tag, input bit wr, input bit mult, input logic [15:0] nblk,
                                 input logic [31:0] to_val, input int rx_max, input int force_idx);
        int tgt, done, rdp, wrp, wraps;
        int rd0, wr0, wp0, q0;
        bit err, hung;
        for (int b = 0; b < 8; b++) begin
            rx_idx[b] = (force_idx >= 0) ? force_idx : int'($urandom_range(0, rx_max));
            rx_dat[b] = $urandom;
        end
        tgt = (!mult || nblk == 0) ? 1 : int'(nblk);
        err = 0;
        done = 0;
        for (int b = 0; b < tgt; b++) begin
            if (to_val != 0 && rx_idx[b] >= int'(to_val)) begin
                err = 1;
                break;
            end
            done++;
        end
        rdp   = wr ? (err ? done + 1 : tgt) : 0;
        wrp   = wr ? 0 : done;
        wraps = wr ? 0 : (err ? done : tgt - 1);
        rd0 = rd_cnt; wr0 = wr_cnt; wp0 = wrap_cnt; q0 = wq.size();
        drive_xfer(wr, mult, nblk, to_val, hung);

        n_total++; if (hung) $display("FAIL %s_hang: complete never rose within budget", tag); else n_pass++;
        n_total++; if (error_timeout !== err) $display("FAIL %s_error: got %b want %b", tag, error_timeout, err); else n_pass++;
        n_total++; if (blocks_done !== 16'(done)) $display("FAIL %s_blocks_done: got %0d want %0d", tag, blocks_done, done); else n_pass++;
        n_total++; if (rd_cnt - rd0 != rdp) $display("FAIL %s_rd_pulses: got %0d want %0d", tag, rd_cnt - rd0, rdp); else n_pass++;
        n_total++; if (wr_cnt - wr0 != wrp) $display("FAIL %s_wr_pulses: got %0d want %0d", tag, wr_cnt - wr0, wrp); else n_pass++;
        n_total++; if (wrap_cnt - wp0 != wraps) $display("FAIL %s_wrap_pulses: got %0d want %0d", tag, wrap_cnt - wp0, wraps); else n_pass++;
        for (int i = 0; i < wrp; i++) begin
            n_total++;
            if (q0 + i >= wq.size()) $display("FAIL %s_wdata%0d: missing, want %h", tag, i, rx_dat[i]);
            else if (wq[q0 + i] !== rx_dat[i]) $display("FAIL %s_wdata%0d: got %h want %h", tag, i, wq[q0 + i], rx_dat[i]);
            else n_pass++;
        end
        ack_in = 1;
        #1;
        n_total++; if (ack_out !== 1'b1) $display("FAIL %s_ack_out: got %b want 1", tag, ack_out); else n_pass++;
        tick();
        ack_in = 0;
        if (hung) begin
            idle_in = 1;
            tick();
            idle_in = 0;
        end
        n_total++; if (serial_ready !== 1'b1) $display("FAIL %s_back_idle: got %b want 1", tag, serial_ready); else n_pass++;
        n_total++; if (blocks_done !== 16'(done)) $display("FAIL %s_done_hold: got %0d want %0d", tag, blocks_done, done); else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        tick();
        n_total++; if (serial_ready !== 1'b1) $display("FAIL reset_serial_ready: got %b want 1", serial_ready); else n_pass++;
        n_total++; if (reset_wrapper !== 1'b1) $display("FAIL reset_wrapper: got %b want 1", reset_wrapper); else n_pass++;
        n_total++;
        if ({complete, ack_out, load_send, enable_pts, enable_stp, waiting_response,
             pad_state, pad_enable, fifo_rd_en, fifo_wr_en, error_timeout} !== 11'b0)
            $display("FAIL reset_outputs_low: got %b want 0", {complete, ack_out, load_send, enable_pts,
                     enable_stp, waiting_response, pad_state, pad_enable, fifo_rd_en, fifo_wr_en, error_timeout});
        else n_pass++;
        n_total++; if (blocks_done !== 16'd0) $display("FAIL reset_blocks_done: got %0d want 0", blocks_done); else n_pass++;
        n_total++; if (fifo_wdata !== 32'd0) $display("FAIL reset_fifo_wdata: got %h want 0", fifo_wdata); else n_pass++;
        reset = 0;
        tick();
    endtask

    task automatic test_timeout();
        test_transfer("timeout", 1'b0, 1'b0, 16'd1, 32'd10, 0, 1000);
        n_total++; if (recv_cycles != 10) $display("FAIL timeout_read_cycles: got %0d want 10", recv_cycles); else n_pass++;
    endtask

    task automatic test_fifo_full();
        logic [31:0] d;
        int w0;
        d = $urandom;
        write_read = 0; multiple = 0; blocks = 1; timeout_val = 0;
        strobe_in = 1;
        tick();
        strobe_in = 0;
        w0 = wr_cnt;
        data_read = d; reception_complete = 1; fifo_full = 1;
        tick();
        reception_complete = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_total++; if (fifo_wr_en !== 1'b0) $display("FAIL full_hold%0d: got %b want 0", i, fifo_wr_en); else n_pass++;
            tick();
        end
        fifo_full = 0;
        #1;
        n_total++; if (fifo_wr_en !== 1'b1) $display("FAIL full_release: got %b want 1", fifo_wr_en); else n_pass++;
        n_total++; if (fifo_wdata !== d) $display("FAIL full_wdata: got %h want %h", fifo_wdata, d); else n_pass++;
        tick();
        n_total++; if (complete !== 1'b1) $display("FAIL full_complete: got %b want 1", complete); else n_pass++;
        n_total++; if (wr_cnt - w0 != 1) $display("FAIL full_pulse_count: got %0d want 1", wr_cnt - w0); else n_pass++;
        ack_in = 1;
        tick();
        ack_in = 0;
    endtask

    task automatic test_abort();
        write_read = 1; multiple = 0; blocks = 1; timeout_val = 0;
        strobe_in = 1;
        tick();
        strobe_in = 0;
        fifo_empty = 0;
        tick();
        fifo_empty = 1;
        n_total++; if (load_send !== 1'b1) $display("FAIL abort_in_send: got %b want 1", load_send); else n_pass++;
        idle_in = 1;
        tick();
        idle_in = 0;
        n_total++; if (serial_ready !== 1'b1) $display("FAIL abort_serial_ready: got %b want 1", serial_ready); else n_pass++;
        n_total++; if (error_timeout !== 1'b0) $display("FAIL abort_error: got %b want 0", error_timeout); else n_pass++;
        n_total++; if (complete !== 1'b0) $display("FAIL abort_complete: got %b want 0", complete); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int rd0;
        write_read = 1; multiple = 1; blocks = 4; timeout_val = 0;
        strobe_in = 1;
        tick();
        strobe_in = 0;
        rd0 = rd_cnt;
        fifo_empty = 0;
        reset = 1;
        #1;
        n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL rstmid_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
        tick();
        reset = 0;
        fifo_empty = 1;
        tick();
        n_total++; if (rd_cnt - rd0 != 0) $display("FAIL rstmid_rd_pulses: got %0d want 0", rd_cnt - rd0); else n_pass++;
        n_total++; if (serial_ready !== 1'b1) $display("FAIL rstmid_idle: got %b want 1", serial_ready); else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            test_transfer("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          16'($urandom_range(0, 8)),
                          ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 10)),
                          int'($urandom_range(0, 9)), -1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time budget expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1; write_read = 0; multiple = 0; blocks = 0; timeout_val = 0; data_read = 0;
        test_reset();
        test_transfer("single_write", 1'b1, 1'b0, 16'($urandom_range(0, 5)), 32'd0, 6, -1);
        test_transfer("multi_read", 1'b0, 1'b1, 16'd3, 32'd0, 6, -1);
        test_timeout();
        test_fifo_full();
        test_abort();
        test_transfer("race", 1'b0, 1'b0, 16'd1, 32'd5, 0, 4);
        test_transfer("multi_write", 1'b1, 1'b1, 16'd4, 32'd0, 6, -1);
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sd_dat_phy_fsm.md
SD_DAT_PHY_FSM -- requirements
Module: sd_dat_phy_fsm

Interface
REQ-001 SHALL have parameter DATA_W, default 32, FIFO and wrapper data width in bits.
REQ-002 SHALL have parameter BLKCNT_W, default 16, block-count width in bits.
REQ-003 SHALL have parameter TO_W, default 32, timeout-counter width in bits.
REQ-004 SHALL have parameter RESP_DLY, default 2, number of WAIT_RESP cycles before enable_stp is asserted.
REQ-005 SHALL have ports, clock and reset first: sd_clock in 1 clock; reset in 1 reset, synchronous, active-high, on clock sd_clock.
REQ-006 SHALL have host-side ports: strobe_in in 1 request; ack_in in 1 host acknowledge; idle_in in 1 abort; write_read in 1 (1=write, 0=read); multiple in 1 multi-block enable; blocks in BLKCNT_W block total; timeout_val in TO_W timeout in cycles, 0=disabled.
REQ-007 SHALL have host-side outputs: serial_ready out 1 idle/ready; complete out 1 transfer finished; ack_out out 1 acknowledge echo; error_timeout out 1 timeout flag; blocks_done out BLKCNT_W completed blocks.
REQ-008 SHALL have wrapper-side ports: transmission_complete in 1; reception_complete in 1; data_read in DATA_W; reset_wrapper out 1; load_send out 1; enable_pts out 1; enable_stp out 1; waiting_response out 1.
REQ-009 SHALL have pad ports: pad_state out 1 (1=drive); pad_enable out 1.
REQ-010 SHALL have FIFO ports: fifo_empty in 1; fifo_full in 1; fifo_rd_en out 1; fifo_wr_en out 1; fifo_wdata out DATA_W.

Function
REQ-011 SHALL implement the states IDLE, LOAD, SEND, WAIT_RESP, READ, PUSH, WRAP_RST and WAIT_ACK, with all control outputs decoded from state alone (Moore).
REQ-012 IDLE SHALL assert serial_ready and reset_wrapper; on strobe_in it SHALL latch blocks/multiple/write_read/timeout_val and go to LOAD if write, else READ.
REQ-013 Effective block target SHALL be 1 when multiple=0 or blocks=0, else blocks.
REQ-014 LOAD SHALL wait while fifo_empty=1; when fifo_empty=0 it SHALL pulse fifo_rd_en for one cycle, assert enable_pts, pad_state and pad_enable, then go to SEND.
REQ-015 SEND SHALL assert load_send, enable_pts, pad_state and pad_enable; on transmission_complete it SHALL go to WAIT_RESP.
REQ-016 WAIT_RESP SHALL assert waiting_response and pad_enable with pad_state=0, and SHALL assert enable_stp only after RESP_DLY cycles in the state; on reception_complete it SHALL increment blocks_done, then go to WAIT_ACK if target reached, else LOAD.
REQ-017 READ SHALL assert enable_stp and pad_enable; on reception_complete it SHALL increment blocks_done and go to PUSH.
REQ-018 PUSH SHALL wait while fifo_full=1; when fifo_full=0 it SHALL assert fifo_wr_en for exactly one cycle with fifo_wdata=data_read, then go to WAIT_ACK if target reached, else WRAP_RST.
REQ-019 WRAP_RST SHALL assert reset_wrapper for one cycle, then go to READ.
REQ-020 Timeout counter SHALL clear on entry to WAIT_RESP or READ, increment each cycle in those states, and saturate; when it equals a nonzero latched timeout_val, the block SHALL set error_timeout and go to WAIT_ACK.
REQ-021 reception_complete and timeout in the same cycle SHALL resolve as completion, with no error.
REQ-022 WAIT_ACK SHALL assert complete; ack_out SHALL equal ack_in; on ack_in it SHALL go to IDLE.
REQ-023 error_timeout and blocks_done SHALL hold until the next strobe_in accepted in IDLE, where both clear.
REQ-024 idle_in SHALL force IDLE on the next edge from any state without setting error_timeout; idle_in has priority over all transitions except reset.
REQ-025 blocks_done SHALL wrap modulo 2^BLKCNT_W.

Reset
REQ-026 On reset the state SHALL be IDLE and timeout counter, blocks_done, error_timeout and fifo_wdata SHALL be 0; all outputs SHALL take IDLE decode (serial_ready=1, reset_wrapper=1, all others 0).
REQ-027 Reset mid-transfer SHALL abandon the transfer without issuing any further FIFO strobe.

Structure
REQ-028 State encoding and default parameter values SHALL reside in shared package sd_dat_pkg.
REQ-029 The timeout counter SHALL be sub-module sd_timeout_cnt (clear, enable, limit, expired).

Verification
REQ-030 Single write: write_read=1, multiple=0, fifo_empty=0 -> exactly one fifo_rd_en pulse, complete=1, blocks_done=1.
REQ-031 Multi-read, blocks=3 -> three fifo_wr_en pulses with fifo_wdata = respective data_read values, two reset_wrapper pulses between blocks, blocks_done=3.
REQ-032 Read with timeout_val=10 and no reception_complete -> error_timeout=1 after 10 cycles in READ, complete=1.
REQ-033 fifo_full=1 for 5 cycles in PUSH -> fifo_wr_en stays 0 until release, then exactly one pulse.
REQ-034 idle_in in SEND -> IDLE next cycle, serial_ready=1, error_timeout=0.
REQ-035 Timeout and reception_complete in the same cycle -> error_timeout=0, blocks_done incremented.
